// File: rtl/microwave_control.sv
// Front-panel sequencer for the microwave timer: conditions the buttons,
// steps IDLE/COOK/PAUSE/DONE and drives the encoder, timer and magnetron.
module microwave_control #(
    parameter int DONE_CYCLES = 300,
    parameter int MAX_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       loadn,
    input  logic       timer_zero,
    output logic       enablen,
    output logic       digit_load,
    output logic       timer_clrn,
    output logic       count_en,
    output logic       mag_on,
    output logic       lamp_on,
    output logic       done,
    output logic [2:0] digit_cnt
);

    localparam int CW = $clog2(DONE_CYCLES);

    typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    start_q, stop_q, load_q, door_q;
    logic          start_prev_q, stop_prev_q, load_prev_q;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          load_q_o, load_d;
    logic          clrn_q, clrn_d;
    logic          enablen_q, count_q, mag_q, lamp_q, done_q;
    logic          start_ev, stop_ev, digit_ev, door_s;

    // Synchronizers idle at the released level so reset never fakes an edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q      <= 2'b11;
            stop_q       <= 2'b11;
            load_q       <= 2'b11;
            door_q       <= 2'b11;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            load_prev_q  <= 1'b1;
        end else begin
            start_q      <= {start_q[0], startn};
            stop_q       <= {stop_q[0], stopn};
            load_q       <= {load_q[0], loadn};
            door_q       <= {door_q[0], door_closed};
            start_prev_q <= start_q[1];
            stop_prev_q  <= stop_q[1];
            load_prev_q  <= load_q[1];
        end
    end

    assign start_ev = start_prev_q & ~start_q[1];
    assign stop_ev  = stop_prev_q & ~stop_q[1];
    assign digit_ev = load_prev_q & ~load_q[1];
    assign door_s   = door_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        load_d  = 1'b0;
        clrn_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (stop_ev) begin
                    clrn_d = 1'b0;
                    cnt_d  = '0;
                end else if (start_ev) begin
                    if (door_s && !timer_zero) begin
                        state_d = COOK;
                        cnt_d   = '0;
                    end
                end else if (digit_ev && cnt_q < 3'(MAX_DIGITS)) begin
                    load_d = 1'b1;
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            COOK: begin
                if (timer_zero) begin
                    state_d = DONE;
                    dcnt_d  = CW'(DONE_CYCLES - 1);
                end else if (!door_s || stop_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_ev) begin
                    state_d = IDLE;
                    clrn_d  = 1'b0;
                end else if (start_ev && door_s) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (stop_ev || dcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            load_q_o  <= 1'b0;
            clrn_q    <= 1'b0;
            enablen_q <= 1'b0;
            count_q   <= 1'b0;
            mag_q     <= 1'b0;
            lamp_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            load_q_o  <= load_d;
            clrn_q    <= clrn_d;
            enablen_q <= (state_d == COOK) || (state_d == PAUSE);
            count_q   <= (state_d == COOK);
            mag_q     <= (state_d == COOK);
            lamp_q    <= (state_d == COOK) || !door_s;
            done_q    <= (state_d == DONE);
        end
    end

    assign enablen    = enablen_q;
    assign digit_load = load_q_o;
    assign timer_clrn = clrn_q;
    assign count_en   = count_q;
    assign mag_on     = mag_q;
    assign lamp_on    = lamp_q;
    assign done       = done_q;
    assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_microwave_control.sv
// Bench for microwave_control: vector table, corner sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_microwave_control;

    localparam int DC = 300;
    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic       loadn = 1'b1;
    logic       timer_zero = 1'b0;
    logic       enablen, digit_load, timer_clrn, count_en;
    logic       mag_on, lamp_on, done;
    logic [2:0] digit_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    microwave_control #(.DONE_CYCLES(DC), .MAX_DIGITS(MD)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .loadn(loadn), .timer_zero(timer_zero),
        .enablen(enablen), .digit_load(digit_load), .timer_clrn(timer_clrn),
        .count_en(count_en), .mag_on(mag_on), .lamp_on(lamp_on),
        .done(done), .digit_cnt(digit_cnt)
    );

    // Model: raw-input history per button, mode 0 idle/1 cook/2 pause/3 done
    bit h_st[3], h_sp[3], h_ld[3], h_dr[3];
    int m_mode, m_digits, m_left;
    bit m_load, m_clr, m_lamp;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h_st[i] = 1; h_sp[i] = 1; h_ld[i] = 1; h_dr[i] = 1;
        end
        m_mode = 0; m_digits = 0; m_left = 0;
        m_load = 0; m_clr = 1; m_lamp = 0;
    endtask

    task automatic model_step();
        bit st, sp, ld, dr;
        st = h_st[2] && !h_st[1];
        sp = h_sp[2] && !h_sp[1];
        ld = h_ld[2] && !h_ld[1];
        dr = h_dr[1];
        m_load = 0;
        m_clr = 0;
        if (m_mode == 0) begin
            if (sp) begin
                m_clr = 1; m_digits = 0;
            end else if (st) begin
                if (dr && !timer_zero) begin
                    m_mode = 1; m_digits = 0;
                end
            end else if (ld && m_digits < MD) begin
                m_digits++; m_load = 1;
            end
        end else if (m_mode == 1) begin
            if (timer_zero) begin
                m_mode = 3; m_left = DC;
            end else if (!dr || sp) m_mode = 2;
        end else if (m_mode == 2) begin
            if (sp) begin
                m_mode = 0; m_clr = 1;
            end else if (st && dr) m_mode = 1;
        end else begin
            m_left--;
            if (sp || m_left == 0) m_mode = 0;
        end
        m_lamp = (m_mode == 1) || !dr;
        h_st[2] = h_st[1]; h_st[1] = h_st[0]; h_st[0] = startn;
        h_sp[2] = h_sp[1]; h_sp[1] = h_sp[0]; h_sp[0] = stopn;
        h_ld[2] = h_ld[1]; h_ld[1] = h_ld[0]; h_ld[0] = loadn;
        h_dr[2] = h_dr[1]; h_dr[1] = h_dr[0]; h_dr[0] = door_closed;
    endtask

    function automatic logic [9:0] model_vec();
        bit cook;
        cook = (m_mode == 1);
        return {(m_mode == 1 || m_mode == 2), m_load, !m_clr, cook, cook,
                m_lamp, (m_mode == 3), 3'(m_digits)};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {enablen, digit_load, timer_clrn, count_en, mag_on,
                lamp_on, done, digit_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (resetn) model_step();
        @(negedge clk);
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    typedef struct {
        logic st, sp, dr, ld;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, sp, dr, ld, en, ce, mg, lp, dn,
                       input logic [2:0] dc);
        vec_t v;
        v.st = st; v.sp = sp; v.dr = dr; v.ld = ld;
        v.exp = {en, ce, mg, lp, dn, dc};
        tbl.push_back(v);
    endtask

    int n, m;

    initial begin
        // startn stopn door loadn | enablen count mag lamp done digits
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 3);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 4);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 4);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 4);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'(model_vec()));
        check("reset_clrn_low", 32'(timer_clrn), 0);
        resetn = 1'b1;
        cyc();
        check("clrn_after_release", 32'(timer_clrn), 1);

        foreach (tbl[i]) begin
            startn = tbl[i].st; stopn = tbl[i].sp;
            door_closed = tbl[i].dr; loadn = tbl[i].ld;
            repeat (4) cyc();
            check($sformatf("vec%0d", i),
                  32'({enablen, count_en, mag_on, lamp_on, done, digit_cnt}),
                  32'(tbl[i].exp));
        end

        // One held key gives one load pulse; stop gives one clear pulse
        n = 0;
        loadn = 1'b0;
        repeat (4) begin cyc(); if (digit_load) n++; end
        loadn = 1'b1;
        repeat (4) begin cyc(); if (digit_load) n++; end
        check("load_pulses", n, 1);
        check("digits_one", 32'(digit_cnt), 1);
        n = 0;
        stopn = 1'b0;
        repeat (4) begin cyc(); if (!timer_clrn) n++; end
        stopn = 1'b1;
        repeat (4) begin cyc(); if (!timer_clrn) n++; end
        check("clr_pulses", n, 1);
        check("digits_cleared", 32'(digit_cnt), 0);

        // Start and stop together in IDLE: clear wins
        loadn = 1'b0; repeat (4) cyc();
        loadn = 1'b1; repeat (2) cyc();
        n = 0; m = 0;
        startn = 1'b0; stopn = 1'b0;
        repeat (4) begin cyc(); if (!timer_clrn) n++; if (mag_on) m++; end
        startn = 1'b1; stopn = 1'b1;
        repeat (4) begin cyc(); if (!timer_clrn) n++; if (mag_on) m++; end
        check("simul_clr", n, 1);
        check("simul_no_cook", m, 0);
        check("simul_state", 32'({enablen, digit_cnt}), 0);

        // Start refused while the timer reads zero
        timer_zero = 1'b1;
        startn = 1'b0; repeat (4) cyc();
        startn = 1'b1; repeat (2) cyc();
        check("tz_start_ignored", 32'({enablen, mag_on}), 0);
        timer_zero = 1'b0;

        // Cook to completion, done held exactly DC cycles
        startn = 1'b0; repeat (4) cyc();
        startn = 1'b1; repeat (2) cyc();
        check("cook_on", 32'({enablen, count_en, mag_on}), 3'b111);
        timer_zero = 1'b1;
        cyc();
        check("done_entry", 32'({done, mag_on, count_en}), 3'b100);
        timer_zero = 1'b0;
        n = 1;
        for (int i = 0; i < DC + 100; i++) begin
            cyc();
            if (done) n++;
            else break;
        end
        check("done_len", n, DC);
        check("after_done", 32'({enablen, done, mag_on}), 0);

        // Asynchronous reset in the middle of a cook
        startn = 1'b0; repeat (4) cyc();
        startn = 1'b1; repeat (2) cyc();
        check("cook_before_rst", 32'(mag_on), 1);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst", 32'({mag_on, timer_clrn, enablen, count_en}), 0);
        @(negedge clk);
        check("rst_hold", 32'(dut_vec()), 32'(model_vec()));
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (digit_load || !timer_clrn || enablen || mag_on) n++;
        end
        check("no_spurious", n, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) startn = ~startn;
            if ($urandom_range(0, 9) == 0) stopn = ~stopn;
            if ($urandom_range(0, 3) == 0) loadn = ~loadn;
            if ($urandom_range(0, 23) == 0) door_closed = ~door_closed;
            timer_zero = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_control.md
# microwave_control

Top-level sequencing controller for the microwave timer datapath. It takes the start/stop buttons, the door sensor, the keypad digit strobe and the countdown's zero flag. It sequences the keypad encoder (entry mode vs. 1 Hz count mode), the time register (digit shift, clear), the countdown enable and the magnetron. It sits between the front-panel inputs and the encoder/countdown datapath, clocked from the same 100 Hz system clock.

## Interface
- DONE_CYCLES, 300, clk cycles the done indication is held (3 s at 100 Hz); minimum 2
- MAX_DIGITS, 4, maximum keypad digits accepted per entry (MM:SS)
- clk  in  1  100 Hz system clock, rising-edge
- resetn  in  1  asynchronous, active-low reset
- startn  in  1  raw start button, active-low, asynchronous to clk
- stopn  in  1  raw stop/clear button, active-low, asynchronous to clk
- door_closed  in  1  door sensor level, 1 = closed, asynchronous to clk
- loadn  in  1  encoder key-valid, low while a digit key is held, asynchronous to clk
- timer_zero  in  1  countdown all-zero flag, synchronous to clk
- enablen  out  1  0 = encoder in keypad-entry mode; 1 = encoder passes 1 Hz count clock
- digit_load  out  1  one-cycle pulse: shift current BCD digit into the time register
- timer_clrn  out  1  active-low, one-cycle clear of the time register
- count_en  out  1  countdown decrement enable
- mag_on  out  1  magnetron drive
- lamp_on  out  1  cavity lamp
- done  out  1  cook-complete indication
- digit_cnt  out  3  digits accepted in the current entry, 0..MAX_DIGITS

## Operation
- Input conditioning:
  - startn, stopn, loadn and door_closed each pass through a 2-FF synchronizer.
  - start_ev, stop_ev and digit_ev are single-cycle events on the synchronized falling edge (1→0).
  - A held button generates exactly one event.
- State machine: IDLE, COOK, PAUSE, DONE. All outputs are registered and decoded from the next state.
- IDLE (enablen=0, count_en=0, mag_on=0):
  - digit_ev with digit_cnt<MAX_DIGITS → digit_load pulse, digit_cnt+1.
  - digit_ev at digit_cnt=MAX_DIGITS → ignored.
  - stop_ev → timer_clrn pulse, digit_cnt=0.
  - start_ev with door_closed=1 and timer_zero=0 → COOK, digit_cnt=0.
  - start_ev otherwise → ignored.
- COOK (enablen=1, count_en=1, mag_on=1, lamp_on=1):
  - timer_zero=1 → DONE.
  - else door_closed=0 or stop_ev → PAUSE.
- PAUSE (enablen=1, count_en=0, mag_on=0): the time register is held.
  - stop_ev → IDLE with timer_clrn pulse.
  - start_ev with door_closed=1 → COOK.
- DONE (done=1, all else off):
  - A down-counter loads DONE_CYCLES-1 on entry.
  - Exit to IDLE on reaching 0 or on stop_ev; no clear is issued.
  - start_ev and digit_ev are ignored.
- lamp_on = 1 in COOK, or whenever the synchronized door_closed=0 in any state.
- Same-cycle priority:
  - IDLE: stop_ev > start_ev > digit_ev. A losing event is discarded, not queued.
  - COOK: timer_zero > door open > stop_ev. A start_ev in COOK is ignored.
  - PAUSE: stop_ev > start_ev.
- digit_cnt saturates at MAX_DIGITS and never wraps. Its width is sufficient for MAX_DIGITS ≤ 7.

## Timing
- Reset values while resetn=0:
  - state=IDLE, enablen=0, digit_load=0, count_en=0, mag_on=0, lamp_on=0, done=0, digit_cnt=0.
  - timer_clrn=0, so the time register is cleared during reset; it returns to 1 on the first clk edge after release.
  - Synchronizer flops reset to the inactive level (1 for startn/stopn/loadn, 1 for door_closed). No spurious event fires after release.
- Latency: a raw input change set up before rising edge k is reflected on the outputs after edge k+2 (3 edges).
- timer_zero is used unsynchronized: COOK→DONE takes effect on the edge after timer_zero is sampled high. mag_on and count_en drop the same cycle.
- digit_load and timer_clrn are exactly one clk wide.
- Door open in COOK: mag_on falls within 3 edges of the raw door change.
- Reset asserted mid-operation forces the reset values immediately (asynchronously), including mag_on=0.

## Test plan
- Entry and cook: release reset; key 4 digits, then a 5th key → digit_load pulses 4 times, digit_cnt=4. Press start with door closed and timer_zero=0 → COOK, enablen=1, mag_on=1, count_en=1, digit_cnt=0.
- Completion: in COOK, raise timer_zero → next edge DONE, mag_on=0, done=1 for exactly 300 cycles, then IDLE with enablen=0.
- Door interlock: open door in COOK → PAUSE, mag_on=0, lamp_on=1. Press start while open → stays PAUSE. Close door, press start → COOK.
- Stop/clear: stop in COOK → PAUSE. Stop again → IDLE with one timer_clrn low pulse. Stop in IDLE → one more pulse, digit_cnt=0.
- Simultaneity: start_ev and stop_ev in the same cycle in IDLE → clear only, no COOK. Start with timer_zero=1 → stays IDLE.
- Async reset: assert resetn low mid-COOK between edges → mag_on=0 and timer_clrn=0 immediately. After release, all outputs are at reset values and no events are generated while buttons stay released.
